// File: rtl/rsa_div_pkg.sv
// Shared types for the RSA restoring divider: controller state encoding and
// the iteration-counter width helper.
package rsa_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    if (w <= 2) begin
      return 1;
    end else begin
      return $clog2(w);
    end
  endfunction

endpackage

// File: rtl/mod_sub_step.sv
// One unsigned compare-subtract step; the only arithmetic of the divider and
// the unit shared with the subtract datapath.
module mod_sub_step #(
  parameter int W = 5
) (
  input  logic [W-1:0] s,
  input  logic [W-1:0] n,
  output logic [W-1:0] diff,
  output logic         ge
);

  logic borrow_s;

  // ge is the inverse of the borrow out of the W-bit subtraction.
  assign {borrow_s, diff} = {1'b0, s} - {1'b0, n};
  assign ge = ~borrow_s;

endmodule

// File: rtl/mod_div_ctrl.sv
// Sequential restoring division q = a / n, r = a % n, one quotient bit per cycle.
// Optional MOD_DIV_EARLY_EXIT_EN: finish immediately when a < n (variable latency).
module mod_div_ctrl
  import rsa_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_err
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] quo_r;
  // Partial remainder; its extra top bit is always 0 after a step, so it is not stored.
  logic [WIDTH-1:0] rem_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic             div_err_r;

  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   step_s_s;
  logic [WIDTH:0]   step_n_s;
  logic [WIDTH:0]   step_diff_s;
  logic             step_ge_s;
  logic [WIDTH-1:0] rem_next_s;
  logic             unused_diff_msb_s;

  assign shift_s = {rem_r, quo_r[WIDTH-1]};

  // Select operands for the shared step: the shifted remainder while iterating.
  always_comb begin
    step_s_s = shift_s;
    step_n_s = {1'b0, div_r};
`ifdef MOD_DIV_EARLY_EXIT_EN
    if (state_r == IDLE) begin
      step_s_s = {1'b0, a};
      step_n_s = {1'b0, n};
    end else begin
      step_s_s = shift_s;
      step_n_s = {1'b0, div_r};
    end
`endif
  end

  mod_sub_step #(.W(WIDTH + 1)) u_step (
    .s    (step_s_s),
    .n    (step_n_s),
    .diff (step_diff_s),
    .ge   (step_ge_s)
  );

  assign rem_next_s        = step_ge_s ? step_diff_s[WIDTH-1:0] : shift_s[WIDTH-1:0];
  assign unused_diff_msb_s = step_diff_s[WIDTH];

  // Controller FSM with datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      div_r       <= '0;
      quo_r       <= '0;
      rem_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      q_r         <= '0;
      r_r         <= '0;
      div_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            div_r      <= n;
            quo_r      <= a;
            rem_r      <= '0;
            cnt_r      <= CW'(WIDTH - 1);
            in_ready_r <= 1'b0;
            if (n == '0) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              q_r         <= '1;
              r_r         <= a;
              div_err_r   <= 1'b1;
`ifdef MOD_DIV_EARLY_EXIT_EN
            end else if (!step_ge_s) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              q_r         <= '0;
              r_r         <= a;
              div_err_r   <= 1'b0;
`endif
            end else begin
              state_r <= ITER;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ITER: begin
          rem_r <= rem_next_s;
          quo_r <= {quo_r[WIDTH-2:0], step_ge_s};
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == '0) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            q_r         <= {quo_r[WIDTH-2:0], step_ge_s};
            r_r         <= rem_next_s;
            div_err_r   <= 1'b0;
          end else begin
            state_r <= ITER;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign q         = q_r;
  assign r         = r_r;
  assign div_err   = div_err_r;

endmodule

// File: tb/tb_mod_div_ctrl.sv
// Scoreboard bench for mod_div_ctrl (WIDTH=4): driver pushes expected results,
// a monitor checks values, latency and hold stability as results appear.
module tb_mod_div_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] n;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_err;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
    int           acc;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mod_div_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .n         (n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .div_err   (div_err)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Present a request at the negedge; returns just after the accepting posedge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] nv,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic ee);
    exp_t e;
    int   lat;
    int   t;
    @(negedge clk);
    a = av;
    n = nv;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
      return;
    end
    lat = (nv == 4'd0) ? 1 : W + 1;
`ifdef MOD_DIV_EARLY_EXIT_EN
    if (nv != 4'd0 && av < nv) lat = 1;
`endif
    e.q = eq; e.r = er; e.err = ee; e.acc = cyc; e.lat = lat;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  // Monitor: compare on each new result, check it holds while stalled.
  initial begin
    logic         prev_ov;
    logic         prev_cons;
    logic [W-1:0] hq;
    logic [W-1:0] hr;
    logic         he;
    exp_t         e;
    prev_ov = 1'b0;
    prev_cons = 1'b0;
    hq = '0; hr = '0; he = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_ov = 1'b0;
        prev_cons = 1'b0;
      end else begin
        if (out_valid) begin
          if (!prev_ov || prev_cons) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_result", 32'd1, 32'd0);
            end else begin
              e = exp_q[0];
              chk("q", q, e.q);
              chk("r", r, e.r);
              chk("div_err", div_err, e.err);
              chk("latency", cyc - e.acc, e.lat);
            end
            hq = q; hr = r; he = div_err;
          end else begin
            chk("hold_q", q, hq);
            chk("hold_r", r, hr);
            chk("hold_err", div_err, he);
          end
          if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
        prev_ov = out_valid;
        prev_cons = out_valid && out_ready;
      end
    end
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rn;
    int           t;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    n = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 32'd1);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_div_err", div_err, 32'd0);

    // 1: a<n and just above n
    send(4'd8, 4'd13, 4'd0, 4'd8, 1'b0);  drop();
    send(4'd13, 4'd12, 4'd1, 4'd1, 1'b0); drop();
    wait_drain();

    // 2: general, n==1, max a with n==1, a==0
    send(4'd12, 4'd9, 4'd1, 4'd3, 1'b0);  drop();
    send(4'd3, 4'd1, 4'd3, 4'd0, 1'b0);   drop();
    send(4'd15, 4'd1, 4'd15, 4'd0, 1'b0); drop();
    send(4'd0, 4'd11, 4'd0, 4'd0, 1'b0);  drop();
    send(4'd10, 4'd10, 4'd1, 4'd0, 1'b0); drop();
    wait_drain();

    // 3: divide by zero, then a normal request
    send(4'd7, 4'd0, 4'hF, 4'd7, 1'b1);   drop();
    send(4'd9, 4'd4, 4'd2, 4'd1, 1'b0);   drop();
    wait_drain();

    // 4: backpressure with ignored requests while busy
    out_ready = 1'b0;
    send(4'd12, 4'd9, 4'd1, 4'd3, 1'b0);  drop();
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("bp_out_valid_seen", out_valid, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 4'd5;
      n = 4'd2;
      in_valid = 1'b1;
      #1;
      chk("bp_in_ready", in_ready, 32'd0);
      chk("bp_out_valid", out_valid, 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain();
    repeat (8) @(negedge clk);
    #1;
    chk("bp_no_extra", out_valid, 32'd0);

    // 5: reset mid-iteration discards the result
    send(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);  drop();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 32'd1);
    chk("mid_rst_out_valid", out_valid, 32'd0);
    chk("mid_rst_q", q, 32'd0);
    chk("mid_rst_r", r, 32'd0);
    send(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);  drop();
    wait_drain();

    // 6: back-to-back stream, in_valid held high
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(0, 15));
      rn = W'($urandom_range(0, 15));
      if (rn == 4'd0) send(ra, rn, 4'hF, ra, 1'b1);
      else send(ra, rn, ra / rn, ra % rn, 1'b0);
    end
    drop();
    wait_drain();
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
